// File: rtl/keypad_scan_if.sv
// Key event handshake between keypad_scan (master) and its consumer (slave).
// With KEYPAD_RELEASE_EVT_EN defined, key_release marks an event as a release.
interface keypad_scan_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       overrun;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic       key_release;

  modport master (
    output key_code, key_valid, key_down, overrun, key_release,
    input  key_ack
  );
  modport slave (
    input  key_code, key_valid, key_down, overrun, key_release,
    output key_ack
  );
`else
  modport master (
    output key_code, key_valid, key_down, overrun,
    input  key_ack
  );
  modport slave (
    input  key_code, key_valid, key_down, overrun,
    output key_ack
  );
`endif
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row drive, frame decode with ghost rejection, debounce, depth-1 event register.
// Optional KEYPAD_RELEASE_EVT_EN adds release events and the key_release output.
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 12000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic             hwclk,
  input  logic             rst_n,
  output logic [3:0]       keypad_r,
  input  logic [3:0]       keypad_c,
  keypad_scan_if.master    evt
);

  typedef struct packed {
    logic       is_key;
    logic [3:0] code;
  } key_state_t;

  localparam key_state_t KEY_NONE = '0;

  logic [3:0]  c_meta, c_sync;
  logic [15:0] div_cnt;
  logic [1:0]  row;
  logic        dwell_end, frame_end;

  // Frame accumulator: low-bit count saturates at 2, which already means ghost.
  logic [1:0]  acc_lows;
  logic [3:0]  acc_code;
  logic [1:0]  samp_lows, tot_lows;
  logic [1:0]  samp_col;
  logic [3:0]  tot_code;
  logic [2:0]  lows_sum;

  key_state_t  cand, cand_nxt, stable, frame_key;
  logic [3:0]  cnt, cnt_nxt;
  logic        ghost, stable_upd;

  logic        evt_req;
  logic [3:0]  evt_req_code;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic        evt_req_rel;
`endif

  assign keypad_r  = ~(4'b0001 << row);
  assign dwell_end = (div_cnt == 16'(SCAN_DIV - 1));
  assign frame_end = dwell_end && (row == 2'd3);

  // NOTE: the synchronizer resets to all-ones (idle columns) so a reset never looks like a press.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      c_meta <= '1;
      c_sync <= '1;
    end else begin
      // NOTE: non-blocking assignments keep both flops sampling the same edge.
      c_meta <= keypad_c;
      c_sync <= c_meta;
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      row     <= '0;
    end else if (dwell_end) begin
      div_cnt <= '0;
      row     <= row + 2'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    samp_lows = 2'd0;
    samp_col  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!c_sync[i]) begin
        if (samp_lows != 2'd2) samp_lows = samp_lows + 2'd1;
        samp_col = 2'(i);
      end
    end
  end

  assign lows_sum = {1'b0, acc_lows} + {1'b0, samp_lows};
  assign tot_lows = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
  assign tot_code = (acc_lows != 2'd0) ? acc_code : {row, samp_col};
  assign ghost    = (tot_lows == 2'd2);

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_lows <= '0;
      acc_code <= '0;
    end else if (frame_end) begin
      acc_lows <= '0;
      acc_code <= '0;
    end else if (dwell_end) begin
      acc_lows <= tot_lows;
      acc_code <= tot_code;
    end
  end

  always_comb begin
    frame_key.is_key = (tot_lows == 2'd1);
    frame_key.code   = (tot_lows == 2'd1) ? tot_code : 4'd0;
    cand_nxt         = cand;
    cnt_nxt          = cnt;
    if (frame_end && !ghost) begin
      if (frame_key == cand) begin
        if (cnt != 4'd15) cnt_nxt = cnt + 4'd1;
      end else begin
        cand_nxt = frame_key;
        cnt_nxt  = 4'd1;
      end
    end
    stable_upd = frame_end && !ghost &&
                 (cnt_nxt >= 4'(DEBOUNCE_SCANS)) && (cand_nxt != stable);
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      cand         <= KEY_NONE;
      cnt          <= '0;
      stable       <= KEY_NONE;
      evt_req      <= 1'b0;
      evt_req_code <= '0;
`ifdef KEYPAD_RELEASE_EVT_EN
      evt_req_rel  <= 1'b0;
`endif
    end else begin
      cand   <= cand_nxt;
      cnt    <= cnt_nxt;
      if (stable_upd) stable <= cand_nxt;
`ifdef KEYPAD_RELEASE_EVT_EN
      // A release reports the key that was held, i.e. the outgoing stable code.
      evt_req      <= stable_upd && (cand_nxt.is_key || stable.is_key);
      evt_req_code <= cand_nxt.is_key ? cand_nxt.code : stable.code;
      evt_req_rel  <= !cand_nxt.is_key;
`else
      evt_req      <= stable_upd && cand_nxt.is_key;
      evt_req_code <= cand_nxt.code;
`endif
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      evt.key_code    <= '0;
      evt.key_valid   <= 1'b0;
      evt.key_down    <= 1'b0;
      evt.overrun     <= 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
      evt.key_release <= 1'b0;
`endif
    end else begin
      evt.key_down <= stable.is_key;
      if (evt_req) begin
        if (!evt.key_valid || evt.key_ack) begin
          evt.key_code    <= evt_req_code;
          evt.key_valid   <= 1'b1;
`ifdef KEYPAD_RELEASE_EVT_EN
          evt.key_release <= evt_req_rel;
`endif
        end else begin
          evt.overrun <= 1'b1;
        end
      end else if (evt.key_ack) begin
        evt.key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=2) with a keypad matrix model
// and an expected-event scoreboard.
module tb_keypad_scan;

  logic        hwclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  keypad_r;
  logic [3:0]  keypad_c;
  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  logic [4:0] sb[$];   // {release, code}

  keypad_scan_if kif();

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .hwclk    (hwclk),
    .rst_n    (rst_n),
    .keypad_r (keypad_r),
    .keypad_c (keypad_c),
    .evt      (kif)
  );

  always #5 hwclk = ~hwclk;

  // A pressed key shorts its row line to its column line.
  always_comb begin
    keypad_c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !keypad_r[r]) keypad_c[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic wait_event(input string tag, input int budget);
    int n = 0;
    logic [4:0] exp;
    while (kif.key_valid !== 1'b1 && n < budget) begin
      @(negedge hwclk);
      n++;
    end
    check({tag, "_valid"}, 32'(kif.key_valid), 32'd1);
    check({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
    if (kif.key_valid === 1'b1 && sb.size() > 0) begin
      exp = sb.pop_front();
      check({tag, "_code"}, 32'(kif.key_code), 32'(exp[3:0]));
`ifdef KEYPAD_RELEASE_EVT_EN
      check({tag, "_release"}, 32'(kif.key_release), 32'(exp[4]));
`endif
    end
  endtask

  task automatic ack(input string tag);
    kif.key_ack = 1'b1;
    @(negedge hwclk);
    kif.key_ack = 1'b0;
    check({tag, "_valid_after_ack"}, 32'(kif.key_valid), 32'd0);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    logic seen_valid = 1'b0;
    logic seen_down  = 1'b0;
    repeat (n) begin
      @(negedge hwclk);
      if (kif.key_valid !== 1'b0) seen_valid = 1'b1;
      if (kif.key_down  !== 1'b0) seen_down  = 1'b1;
    end
    check({tag, "_no_valid"}, 32'(seen_valid), 32'd0);
    check({tag, "_no_down"},  32'(seen_down),  32'd0);
  endtask

  initial begin
    logic [3:0] exp_r;
    kif.key_ack = 1'b0;

    // Reset values while held in reset.
    cycles(3);
    check("rst_keypad_r",  32'(keypad_r),      32'hE);
    check("rst_key_code",  32'(kif.key_code),  32'h0);
    check("rst_key_valid", 32'(kif.key_valid), 32'h0);
    check("rst_key_down",  32'(kif.key_down),  32'h0);
    check("rst_overrun",   32'(kif.overrun),   32'h0);

    // Row scan sequence, 4 cycles per row, starting at row 0.
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_r = ~(4'b0001 << (k / 4));
      check($sformatf("row_k%0d", k), 32'(keypad_r), 32'(exp_r));
      @(negedge hwclk);
    end

    // Ack with nothing pending is ignored; idle keypad gives no events.
    kif.key_ack = 1'b1;
    @(negedge hwclk);
    kif.key_ack = 1'b0;
    watch_quiet("idle", 200);

    // Key 9 (row 2, col 1) held.
    pressed[9] = 1'b1;
    sb.push_back({1'b0, 4'd9});
    wait_event("press9", 3 * 16 + 4);
    check("press9_down", 32'(kif.key_down), 32'd1);
    cycles(40);
    check("press9_hold_valid", 32'(kif.key_valid), 32'd1);
    check("press9_hold_code",  32'(kif.key_code),  32'd9);
    ack("press9");
    pressed[9] = 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
    sb.push_back({1'b1, 4'd9});
    wait_event("release9", 3 * 16 + 4);
    ack("release9");
`endif
    cycles(60);
    check("release9_down",  32'(kif.key_down),  32'd0);
    check("release9_valid", 32'(kif.key_valid), 32'd0);

    // Bouncy key 9 confined to a 15-cycle window: at most one frame sees it.
    for (int t = 0; t < 5; t++) begin
      pressed[9] = ~t[0];
      cycles(3);
    end
    pressed[9] = 1'b0;
    watch_quiet("bounce9", 80);

    // Keys 0 and 5 together form ghost frames.
    pressed[0] = 1'b1;
    pressed[5] = 1'b1;
    watch_quiet("ghost_0_5", 100);
    pressed[0] = 1'b0;
    pressed[5] = 1'b0;
    watch_quiet("ghost_release", 60);

    // Press 3, no ack, release, press 12: code 3 retained, overrun raised.
    pressed[3] = 1'b1;
    sb.push_back({1'b0, 4'd3});
    wait_event("press3", 3 * 16 + 4);
    pressed[3] = 1'b0;
    cycles(60);
    pressed[12] = 1'b1;
    cycles(60);
    check("ovr_valid",   32'(kif.key_valid), 32'd1);
    check("ovr_code",    32'(kif.key_code),  32'd3);
    check("ovr_overrun", 32'(kif.overrun),   32'd1);
    check("ovr_down12",  32'(kif.key_down),  32'd1);

    // Asynchronous reset with an event pending; key 12 stays held.
    #2 rst_n = 1'b0;
    #1;
    check("arst_keypad_r",  32'(keypad_r),      32'hE);
    check("arst_key_valid", 32'(kif.key_valid), 32'd0);
    check("arst_key_code",  32'(kif.key_code),  32'd0);
    check("arst_key_down",  32'(kif.key_down),  32'd0);
    check("arst_overrun",   32'(kif.overrun),   32'd0);
    sb.delete();
    @(negedge hwclk);
    rst_n = 1'b1;
    sb.push_back({1'b0, 4'd12});
    wait_event("repress12", 3 * 16 + 4);
    check("repress12_down", 32'(kif.key_down), 32'd1);
    check("repress12_ovr",  32'(kif.overrun),  32'd0);
    ack("repress12");
    pressed[12] = 1'b0;
    cycles(60);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 12000: clock cycles each row is driven (1 ms at 12 MHz); legal range 4..65535.
REQ-002 Parameter DEBOUNCE_SCANS, default 4: consecutive identical frames required to accept a key state; legal range 1..15.
REQ-003 hwclk  in  1  system clock, 12 MHz; all state on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 keypad_r  out  4  row drives; active-low, exactly one row low at any time.
REQ-006 keypad_c  in  4  column sense; low = pressed; pull-ups are provided at top level.
REQ-007 key_code  out  4  event key index = row*4 + col.
REQ-008 key_valid  out  1  event pending; holds until acknowledged.
REQ-009 key_ack  in  1  consumer acknowledge, sampled each rising edge.
REQ-010 key_down  out  1  level; high while the debounced state is a key.
REQ-011 overrun  out  1  sticky; an event was dropped.

Function
REQ-012 keypad_c SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Row scan: row index 0,1,2,3,0 wrapping; keypad_r = ~(1<<row); advances every SCAN_DIV cycles.
REQ-014 Columns SHALL be sampled only on the last cycle of each row dwell, giving SCAN_DIV-1 cycles of settle.
REQ-015 Frame = 4 row samples; at frame end the raw result SHALL be NONE (no low bits), KEY k (exactly one low bit in the frame), or GHOST (two or more low bits).
REQ-016 GHOST frames SHALL leave the candidate and the frame count unchanged.
REQ-017 Debounce: a candidate equal to the previous frame increments the frame count (saturating); a different candidate resets the count to 1.
REQ-018 The stable state SHALL update when count reaches DEBOUNCE_SCANS and the candidate differs from the stable state.
REQ-019 Stable NONE -> KEY k SHALL generate a press event with code k; KEY j -> KEY k (j != k) SHALL generate a press event for k.
REQ-020 Stable KEY -> NONE SHALL generate no event unless release events are enabled (REQ-029).
REQ-021 Event register has depth 1: an event loads key_code and sets key_valid on the cycle after the stable-state update.
REQ-022 key_valid and key_code SHALL hold until key_ack is sampled high; key_valid then falls the next cycle.
REQ-023 key_ack while key_valid is low SHALL be ignored.
REQ-024 Event plus key_ack in the same cycle: the new event SHALL be loaded and key_valid stays high.
REQ-025 Event while key_valid is high without ack: the new event SHALL be dropped, the old code kept, and overrun set.
REQ-026 key_down SHALL be registered from the stable state.

Reset
REQ-027 When rst_n is low, immediately: keypad_r=4'b1110, key_code=0, key_valid=0, key_down=0, overrun=0; counters, synchronizer and candidate cleared; stable=NONE.
REQ-028 Reset mid-dwell or mid-event SHALL discard all pending state; scanning restarts at row 0 on the first edge after deassertion.

Configuration
REQ-029 Macro KEYPAD_RELEASE_EVT_EN: when defined, adds output key_release (1 bit, reset 0), latched together with key_code; KEY k -> NONE emits a release event with code k and key_release=1; presses load key_release=0; KEY j -> KEY k emits only the press of k.
REQ-030 Without KEYPAD_RELEASE_EVT_EN, the key_release port and all release logic SHALL be absent.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2, frame=16 cycles)
REQ-031 Reset released, no keys -> keypad_r cycles 1110,1101,1011,0111 every 4 cycles; key_valid stays 0 for 200 cycles.
REQ-032 Hold key row2/col1 for 100 cycles -> key_valid=1, key_code=9 and key_down=1 within 3 frames + 4 cycles; ack -> key_valid=0 next cycle.
REQ-033 Key 9 pressed for only one frame, toggling every 3 cycles -> no event, key_down stays 0.
REQ-034 Keys 0 and 5 held together -> GHOST; no event.
REQ-035 Press 3, no ack, release, press 12 -> key_code stays 3, overrun=1; with the macro defined, same stimulus and acks -> events press 3, release 3, press 12.
REQ-036 rst_n pulsed low while key_valid=1 -> all outputs at reset values immediately; held key re-reported after debounce.
